// File: rtl/int2flt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : int2flt_pkg
// Description : Shared state encoding and float-format constants for int2flt.
// Revision    : 1.0 - initial release
// ============================================================================
package int2flt_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_RD_LO = 4'd1,
        ST_RD_HI = 4'd2,
        ST_PREP  = 4'd3,
        ST_NORM  = 4'd4,
        ST_ROUND = 4'd5,
        ST_WR_LO = 4'd6,
        ST_WR_HI = 4'd7,
        ST_DONE  = 4'd8
    } state_t;

    localparam int EXP_BIAS = 15;
    // A magnitude with bit 15 set is 2^15, hence bias + 15.
    localparam int EXP_INIT = EXP_BIAS + 15;
    localparam int MANT_W   = 10;

endpackage
`default_nettype wire

// File: rtl/int2flt_round.sv
`default_nettype none
// ============================================================================
// Module      : int2flt_round
// Description : Round-to-nearest-even of a normalized 16-bit magnitude into a
//               binary16 exponent/mantissa pair, with carry renormalization.
// Revision    : 1.0 - initial release
// ============================================================================
module int2flt_round
    import int2flt_pkg::*;
(
    input  logic [15:0] mag,
    input  logic [4:0]  exp_in,
    output logic [14:0] exp_mant
);

    logic [MANT_W-1:0] mant;
    logic              guard;
    logic              sticky;
    logic              inc;
    logic [MANT_W:0]   mant_sum;
    logic [4:0]        exp_out;

    always_comb begin
        mant     = mag[14:5];
        guard    = mag[4];
        sticky   = |mag[3:0];
        inc      = guard & (sticky | mant[0]);
        mant_sum = {1'b0, mant} + {{MANT_W{1'b0}}, inc};
        // A carry out leaves the low mantissa bits at zero already.
        exp_out  = mant_sum[MANT_W] ? exp_in + 5'd1 : exp_in;
        exp_mant = {exp_out, mant_sum[MANT_W-1:0]};
        if (!mag[15]) begin
            exp_mant = '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/int2flt.sv
`default_nettype none
// ============================================================================
// Module      : int2flt
// Description : Sequential int16 -> binary16 converter over a byte-wide data
//               memory port, with start falling-edge launch and done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module int2flt
    import int2flt_pkg::*;
#(
    parameter logic [7:0] SRC_ADDR = 8'd0,
    parameter logic [7:0] DST_ADDR = 8'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       done,
    output logic       busy,
    output logic [7:0] dm_addr,
    output logic       dm_rd,
    output logic       dm_wr,
    output logic [7:0] dm_wdata,
    input  logic [7:0] dm_rdata
);

    state_t      state_q, state_d;
    logic        start_q, start_d;
    logic [15:0] x_q, x_d;
    logic        sign_q, sign_d;
    logic [15:0] mag_q, mag_d;
    logic [4:0]  exp_q, exp_d;
    logic [15:0] result_q, result_d;

    logic [15:0] abs_x;
    logic [14:0] rnd_exp_mant;

    // 0x8000 negates to itself, which reads as 32768 unsigned.
    assign abs_x = x_q[15] ? (~x_q + 16'd1) : x_q;

    int2flt_round u_round (
        .mag      (mag_q),
        .exp_in   (exp_q),
        .exp_mant (rnd_exp_mant)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            start_q  <= 1'b0;
            x_q      <= '0;
            sign_q   <= 1'b0;
            mag_q    <= '0;
            exp_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            x_q      <= x_d;
            sign_q   <= sign_d;
            mag_q    <= mag_d;
            exp_q    <= exp_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        start_d  = start;
        x_d      = x_q;
        sign_d   = sign_q;
        mag_d    = mag_q;
        exp_d    = exp_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start_q && !start) begin
                    state_d = ST_RD_LO;
                end
            end
            ST_RD_LO: begin
                x_d[7:0] = dm_rdata;
                state_d  = ST_RD_HI;
            end
            ST_RD_HI: begin
                x_d[15:8] = dm_rdata;
                state_d   = ST_PREP;
            end
            ST_PREP: begin
                sign_d = x_q[15];
                mag_d  = abs_x;
                exp_d  = 5'(EXP_INIT);
                if (abs_x == 16'd0) begin
                    result_d = '0;
                    state_d  = ST_WR_LO;
                end else if (abs_x[15]) begin
                    state_d = ST_ROUND;
                end else begin
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                // Look ahead at bit 14 so NORM lasts exactly one cycle per leading zero.
                mag_d = {mag_q[14:0], 1'b0};
                exp_d = exp_q - 5'd1;
                if (mag_q[14]) begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                result_d = {sign_q, rnd_exp_mant};
                state_d  = ST_WR_LO;
            end
            ST_WR_LO: state_d = ST_WR_HI;
            ST_WR_HI: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        done     = 1'b0;
        busy     = (state_q != ST_IDLE);
        dm_addr  = 8'd0;
        dm_rd    = 1'b0;
        dm_wr    = 1'b0;
        dm_wdata = 8'd0;
        case (state_q)
            ST_RD_LO: begin
                dm_addr = SRC_ADDR;
                dm_rd   = 1'b1;
            end
            ST_RD_HI: begin
                dm_addr = SRC_ADDR + 8'd1;
                dm_rd   = 1'b1;
            end
            ST_WR_LO: begin
                dm_addr  = DST_ADDR;
                dm_wr    = 1'b1;
                dm_wdata = result_q[7:0];
            end
            ST_WR_HI: begin
                dm_addr  = DST_ADDR + 8'd1;
                dm_wr    = 1'b1;
                dm_wdata = result_q[15:8];
            end
            ST_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/int2flt.md
# int2flt

Sequential integer-to-half-precision-float converter, the program stage directly upstream of the float-to-integer converter. Reads a 16-bit two's-complement integer from data memory, normalizes it one bit per cycle, rounds to nearest even and writes the IEEE-754 binary16 result back to data memory. Uses the same `start`/`done` test-bench handshake and the same byte-wide `data_mem` port as the rest of the program blocks.

## Interface
- `SRC_ADDR`, default 8'd0: address of the input low byte; the high byte is at `SRC_ADDR+1`.
- `DST_ADDR`, default 8'd2: address of the result low byte; the high byte is at `DST_ADDR+1`.
- `clk` input 1: the single clock.
- `reset` input 1: asynchronous, active-high.
- `start` input 1: request from the test bench.
- `done` output 1: one-cycle acknowledge pulse.
- `busy` output 1: high from conversion launch until `done`.
- `dm_addr` output 8: data-memory address.
- `dm_rd` output 1: read enable.
- `dm_wr` output 1: write enable; the write commits at the `clk` rising edge.
- `dm_wdata` output 8: write data.
- `dm_rdata` input 8: read data, combinational from `dm_addr`.

## Operation
- States: IDLE, RD_LO, RD_HI, PREP, NORM, ROUND, WR_LO, WR_HI, DONE.
- Start detection:
  - `start_q` is `start` registered.
  - Launch occurs on the falling edge of the request, when `start_q && !start` in IDLE.
  - `start` activity outside IDLE is ignored.
- RD_LO: `dm_addr=SRC_ADDR`, `dm_rd=1`, capture the low byte.
- RD_HI: `dm_addr=SRC_ADDR+1`, capture the high byte.
- PREP:
  - `sign=x[15]`.
  - `mag = sign ? -x : x`, 16-bit unsigned, so 0x8000 maps to 32768.
  - `exp = 5'd30`.
  - If `mag==0`, the result is 0x0000 and the state goes directly to WR_LO. There is no negative zero.
- NORM:
  - While `mag[15]==0`: `mag <<= 1`, `exp -= 1`.
  - Exit to ROUND when `mag[15]==1`.
  - NORM takes `s` cycles, where `s` is the leading-zero count (0..15).
- ROUND:
  - `mant = mag[14:5]`, `G = mag[4]`, `S = |mag[3:0]`.
  - Increment if `G && (S || mant[0])`.
  - If the mantissa carries out: `mant=0`, `exp+=1`.
  - Result is `{sign, exp, mant}`.
- Exponent range:
  - The maximum reachable exponent is 30, because inputs up to 32767 round at most to 32768 = 0x7800.
  - Infinity and NaN are never produced.
  - Subnormals are never produced.
- WR_LO: `dm_addr=DST_ADDR`, `dm_wr=1`, `dm_wdata=result[7:0]`.
- WR_HI: `dm_addr=DST_ADDR+1`, `dm_wr=1`, `dm_wdata=result[15:8]`.
- DONE: `done=1` for exactly one cycle, then IDLE.

## Timing
- Reset values:
  - State IDLE.
  - `done=0`, `busy=0`, `dm_rd=0`, `dm_wr=0`, `dm_addr=0`, `dm_wdata=0`.
  - `start_q=0`; all datapath registers are 0.
- Memory-port outputs are decoded from state and registers only, never combinationally from `start`.
- Latency, counted from the first cycle with `start_q && !start`:
  - RD_LO is entered on the next edge.
  - `done` is high 7+s cycles after that edge (nonzero input).
  - Zero input: `done` after 6 cycles.
  - Worst case (input ±1, s=15): 22 cycles.
- `busy` is high in every state except IDLE, including DONE.
- Reset asserted mid-operation:
  - Immediate return to IDLE; no further memory writes; `done` is not pulsed.
  - A half-written result (WR_LO done, WR_HI not) is left as-is.
- `start` pulses during `busy` are not queued. A falling edge coinciding with DONE is also ignored.
- Back-to-back operation: a new falling edge may be accepted the cycle after DONE.

## Structure
- Package `int2flt_pkg`:
  - `typedef enum logic [3:0] state_t` for the state encoding.
  - `localparam EXP_BIAS = 15`, `EXP_INIT = 30`, `MANT_W = 10`.
- One sub-module, `int2flt_round`: combinational.
  - Inputs: `mag[15:0]` normalized, `exp[4:0]`.
  - Output: `{exp, mant}` after round-to-nearest-even and carry renormalization.
  - The top level holds the FSM, handshake, normalization shifter and memory sequencing.

## Test plan
- mem[1:0] = 0x0001, start falling edge -> mem[3:2] = 0x3C00; `done` 22 cycles after launch.
- mem[1:0] = 0xFFFF (−1) -> 0xBC00; mem[1:0] = 0x8000 (−32768) -> 0xF800 with s=0, `done` 7 cycles after launch.
- mem[1:0] = 0x7FFF -> 0x7800 (mantissa carry, exponent increments to 30); 0x0000 -> 0x0000 in 6 cycles.
- Rounding ties:
  - 2049 (0x0801) -> 0x6800 (tie, round to even, down).
  - 2051 (0x0803) -> 0x6802 (tie, round up).
  - 2053 (0x0805) -> 0x6802 (tie, round to even, down).
  - 2055 (0x0807) -> 0x6804 (tie, round up).
- Robustness:
  - Assert `reset` during NORM -> `busy=0` and `dm_wr=0` immediately, no `done`, mem[3:2] unchanged.
  - Extra `start` pulses while busy -> exactly one `done` per accepted launch.
- Exhaustive sweep of all 65536 inputs against a reference-model conversion; every result bit-exact.
